// File: rtl/gyro_fir_scheduler.sv
// rtl/gyro_fir_scheduler.sv - shared-MAC 3-axis gyro high-pass FIR sequencer
module gyro_fir_scheduler #(
    parameter int TAPS      = 10,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              SampleValid,
    input  logic signed [9:0] GyroX,
    input  logic signed [9:0] GyroY,
    input  logic signed [9:0] GyroZ,
    input  logic              FlushHistory,
    output logic signed [9:0] GyroXOut,
    output logic signed [9:0] GyroYOut,
    output logic signed [9:0] GyroZOut,
    output logic              DataReady,
    output logic              Busy,
    output logic              Primed,
    output logic              Overrun
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW = $clog2(TAPS + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = 511;
    localparam logic signed [ACC_W-1:0] SAT_LO = -512;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [9:0]        dline [3][TAPS];
    logic signed [ACC_W-1:0]  acc, acc_sum;
    logic [TW-1:0]            tap;
    logic [1:0]               axis;
    logic [CW-1:0]            count;
    logic signed [9:0]        stage_x, stage_y, tap_res, sample_d;
    logic signed [15:0]       coef_q;
    logic signed [25:0]       prod;
    logic                     last_tap;

    function automatic logic signed [15:0] coef(input logic [TW-1:0] idx);
        case (int'(idx))
            0:       coef = 16'hFDA5;
            1:       coef = 16'h0E32;
            2:       coef = 16'hD54B;
            3:       coef = 16'h52ED;
            4:       coef = 16'h8E58;
            5:       coef = 16'h71A8;
            6:       coef = 16'hAD13;
            7:       coef = 16'h2AB5;
            8:       coef = 16'hF1CE;
            9:       coef = 16'h025B;
            default: coef = 16'h0000;
        endcase
    endfunction

    // Floor shift, then clamp into the signed 10-bit output range.
    function automatic logic signed [9:0] fmt(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> OUT_SHIFT;
        if (r > SAT_HI)      fmt = 10'sd511;
        else if (r < SAT_LO) fmt = -10'sd512;
        else                 fmt = r[9:0];
    endfunction

    always_comb begin
        sample_d = dline[axis][tap];
        coef_q   = coef(tap);
        prod     = sample_d * coef_q;
        acc_sum  = acc + ACC_W'(prod);
        tap_res  = fmt(acc_sum);
        last_tap = (tap == TW'(TAPS - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (SampleValid) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_MAC;
            S_MAC:   if (last_tap && axis == 2'd2) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        Busy      = (state != S_IDLE);
        DataReady = (state == S_DONE);
        Overrun   = SampleValid && (state != S_IDLE);
        Primed    = (count == CW'(TAPS));
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            tap      <= '0;
            axis     <= '0;
            count    <= '0;
            stage_x  <= '0;
            stage_y  <= '0;
            GyroXOut <= '0;
            GyroYOut <= '0;
            GyroZOut <= '0;
            for (int a = 0; a < 3; a++)
                for (int k = 0; k < TAPS; k++)
                    dline[a][k] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (FlushHistory) begin
                        count <= '0;
                        for (int a = 0; a < 3; a++)
                            for (int k = 0; k < TAPS; k++)
                                dline[a][k] <= '0;
                    end
                    // The sample is captured on its strobe edge; a same-cycle flush leaves it alone in D[0].
                    if (SampleValid) begin
                        for (int a = 0; a < 3; a++)
                            for (int k = TAPS - 1; k > 0; k--)
                                dline[a][k] <= FlushHistory ? 10'sd0 : dline[a][k-1];
                        dline[0][0] <= GyroX;
                        dline[1][0] <= GyroY;
                        dline[2][0] <= GyroZ;
                        if (FlushHistory)               count <= CW'(1);
                        else if (count != CW'(TAPS))    count <= count + CW'(1);
                    end
                end
                S_LOAD: begin
                    acc  <= '0;
                    tap  <= '0;
                    axis <= '0;
                end
                S_MAC: begin
                    if (last_tap) begin
                        acc  <= '0;
                        tap  <= '0;
                        axis <= axis + 2'd1;
                        case (axis)
                            2'd0: stage_x <= tap_res;
                            2'd1: stage_y <= tap_res;
                            default: begin
                                GyroXOut <= stage_x;
                                GyroYOut <= stage_y;
                                GyroZOut <= tap_res;
                            end
                        endcase
                    end else begin
                        acc <= acc_sum;
                        tap <= tap + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
